// File: rtl/gmii_rx_pkg.sv
// Shared types and constants for the GMII receive framer and its CRC helper.
package gmii_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA,
        DROP
    } rx_state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;

    // Longest legal preamble run before the SFD.
    localparam logic [2:0]  PRE_MAX       = 3'd7;

    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

endpackage

// File: rtl/crc32_d8.sv
// Combinational CRC-32 step for one byte, LSB first, reflected polynomial.
// No register inside, so the transmit path can share it as-is.
module crc32_d8
    import gmii_rx_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    // Shift the eight data bits through the register, bit 0 first.
    always_comb begin
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            c = (c >> 1) ^ (((c[0] ^ data[i]) != 1'b0) ? CRC_POLY : 32'h0);
        end
        crc_out = c;
    end

endmodule

// File: rtl/gmii_rx_frame.sv
// GMII receive framer: strips preamble/SFD, forwards frame bytes with a
// two-cycle latency, and reports length / FCS status one cycle after EOF.
module gmii_rx_frame
    import gmii_rx_pkg::*;
#(
    parameter int MAX_LEN = 1518,
    parameter int MIN_LEN = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        gmii_rx_dv,
    input  logic [7:0]  gmii_rxd,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    output logic        rx_sof,
    output logic        rx_eof,
    output logic        rx_done,
    output logic [10:0] rx_len,
    output logic        rx_crc_ok,
    output logic        rx_len_err
);

    localparam logic [10:0] MAX_L = 11'(MAX_LEN);
    localparam logic [10:0] MIN_L = 11'(MIN_LEN);

    rx_state_t   state, state_nxt;
    logic [2:0]  pre_cnt, pre_cnt_nxt;
    logic        take;      // byte accepted into the frame this cycle
    logic        sfd_hit;   // SFD seen, frame starts next cycle
    logic [10:0] byte_cnt;
    logic [31:0] crc_q, crc_nxt;

    // One-byte holding stage; it lets EOF be decided once the next dv is seen.
    logic        s1_vld, s1_sof;
    logic [7:0]  s1_data;
    logic        eof_now;

    crc32_d8 u_crc (
        .crc_in  (crc_q),
        .data    (gmii_rxd),
        .crc_out (crc_nxt)
    );

    // Next-state logic: preamble qualification, data acceptance, length cap.
    always_comb begin
        state_nxt   = state;
        pre_cnt_nxt = pre_cnt;
        take        = 1'b0;
        sfd_hit     = 1'b0;
        case (state)
            IDLE: begin
                if (gmii_rx_dv) begin
                    if (gmii_rxd == PREAMBLE_BYTE) begin
                        state_nxt   = PREAMBLE;
                        pre_cnt_nxt = 3'd1;
                    end else begin
                        state_nxt = DROP;
                    end
                end
            end
            PREAMBLE: begin
                if (!gmii_rx_dv) begin
                    state_nxt = IDLE;
                end else if (gmii_rxd == SFD_BYTE) begin
                    state_nxt = DATA;
                    sfd_hit   = 1'b1;
                end else if (gmii_rxd == PREAMBLE_BYTE && pre_cnt != PRE_MAX) begin
                    pre_cnt_nxt = pre_cnt + 3'd1;
                end else begin
                    state_nxt = DROP;
                end
            end
            DATA: begin
                if (!gmii_rx_dv) begin
                    state_nxt = IDLE;
                end else begin
                    take = 1'b1;
                    // This byte brings the count to MAX_LEN: it is the last one.
                    if (byte_cnt == MAX_L - 11'd1) state_nxt = DROP;
                end
            end
            DROP: begin
                if (!gmii_rx_dv) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM and preamble-run registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            pre_cnt <= 3'd0;
        end else begin
            state   <= state_nxt;
            pre_cnt <= pre_cnt_nxt;
        end
    end

    // Byte counter and CRC accumulator, restarted at every SFD.
    always_ff @(posedge clk) begin
        if (!rst_n || sfd_hit) begin
            byte_cnt <= 11'd0;
            crc_q    <= CRC_INIT;
        end else if (take) begin
            byte_cnt <= (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;
            crc_q    <= crc_nxt;
        end
    end

    // First pipeline stage: capture accepted bytes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_sof  <= 1'b0;
            s1_data <= 8'h00;
        end else begin
            s1_vld  <= take;
            s1_sof  <= take && (byte_cnt == 11'd0);
            s1_data <= gmii_rxd;
        end
    end

    // The held byte is last unless the framer is still in DATA with dv high.
    assign eof_now = s1_vld && !(state == DATA && gmii_rx_dv);

    // Output stage: forwarded byte with its framing flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_valid <= 1'b0;
            rx_data  <= 8'h00;
            rx_sof   <= 1'b0;
            rx_eof   <= 1'b0;
        end else begin
            rx_valid <= s1_vld;
            rx_data  <= s1_vld ? s1_data : 8'h00;
            rx_sof   <= s1_sof;
            rx_eof   <= eof_now;
        end
    end

    // Frame status, taken the cycle after EOF while counter/CRC still hold
    // the finished frame (the next SFD cannot arrive before then).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_done    <= 1'b0;
            rx_len     <= 11'd0;
            rx_crc_ok  <= 1'b0;
            rx_len_err <= 1'b0;
        end else begin
            rx_done <= rx_valid && rx_eof;
            if (rx_valid && rx_eof) begin
                rx_len     <= byte_cnt;
                rx_crc_ok  <= (crc_q == CRC_RESIDUE) && (byte_cnt < MAX_L);
                rx_len_err <= (byte_cnt < MIN_L) || (byte_cnt >= MAX_L);
            end
        end
    end

endmodule

// File: tb/tb_gmii_rx_frame.sv
// Randomised bench for gmii_rx_frame with a frame-level reference model.
module tb_gmii_rx_frame;

    localparam int MAX_LEN = 1518;
    localparam int MIN_LEN = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        gmii_rx_dv = 1'b0;
    logic [7:0]  gmii_rxd = 8'h00;
    logic        rx_valid, rx_sof, rx_eof, rx_done, rx_crc_ok, rx_len_err;
    logic [7:0]  rx_data;
    logic [10:0] rx_len;

    gmii_rx_frame #(.MAX_LEN(MAX_LEN), .MIN_LEN(MIN_LEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .gmii_rx_dv (gmii_rx_dv),
        .gmii_rxd   (gmii_rxd),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_sof     (rx_sof),
        .rx_eof     (rx_eof),
        .rx_done    (rx_done),
        .rx_len     (rx_len),
        .rx_crc_ok  (rx_crc_ok),
        .rx_len_err (rx_len_err)
    );

    always #4 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        logic [7:0] d;
        logic       sof;
        logic       eof;
        int         at;
    } exp_byte_t;

    typedef struct {
        int   len;
        logic ok;
        logic chk_ok;
        logic err;
        int   at;
    } exp_done_t;

    exp_byte_t eq[$];
    exp_done_t dq[$];
    logic [7:0] fr[$];

    // Ethernet CRC-32 over the first n bytes of fr (register value, not inverted).
    function automatic logic [31:0] crc_of(input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) begin
                if ((c[0] ^ fr[i][b]) != 1'b0) c = (c >> 1) ^ 32'hEDB88320;
                else                           c = c >> 1;
            end
        end
        return c;
    endfunction

    // Builds len bytes: random payload plus FCS, then optionally flips one bit.
    task automatic make_frame(input int len, input int flip_idx);
        logic [31:0] fcs;
        fr.delete();
        for (int i = 0; i < len - 4; i++) fr.push_back(8'($urandom));
        fcs = ~crc_of(len - 4);
        for (int k = 0; k < 4; k++) fr.push_back(fcs[8*k +: 8]);
        if (flip_idx >= 0) fr[flip_idx] = fr[flip_idx] ^ 8'h01;
    endtask

    task automatic drive(input logic dv, input logic [7:0] d);
        @(posedge clk);
        #1;
        gmii_rx_dv = dv;
        gmii_rxd   = d;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, rx_valid, 0);
        chk({tag, "_sof"}, rx_sof, 0);
        chk({tag, "_eof"}, rx_eof, 0);
        chk({tag, "_done"}, rx_done, 0);
        chk({tag, "_data"}, rx_data, 0);
        chk({tag, "_len"}, rx_len, 0);
        chk({tag, "_crc_ok"}, rx_crc_ok, 0);
        chk({tag, "_len_err"}, rx_len_err, 0);
    endtask

    // Sends npre preamble bytes, sfd, the bytes in fr, then gap idle cycles.
    // rst_at >= 0 pulses reset for one cycle while byte rst_at is on the bus.
    task automatic send(input int npre, input logic [7:0] sfd, input int gap, input int rst_at);
        int  n, fwd;
        bit  accepted, fcs_ok;
        logic [31:0] want;
        n        = fr.size();
        fwd      = (n >= MAX_LEN) ? MAX_LEN : n;
        accepted = (npre >= 1) && (npre <= 7) && (sfd == 8'hD5);
        fcs_ok   = 1'b0;
        if (n >= 4) begin
            want   = ~crc_of(n - 4);
            fcs_ok = (fr[n-4] == want[7:0]) && (fr[n-3] == want[15:8]) &&
                     (fr[n-2] == want[23:16]) && (fr[n-1] == want[31:24]);
        end
        for (int i = 0; i < npre; i++) drive(1'b1, 8'h55);
        drive(1'b1, sfd);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, fr[i]);
            if (rst_at >= 0 && i == rst_at) rst_n = 1'b0;
            if (accepted && i < fwd && (rst_at < 0 || i < rst_at - 1))
                eq.push_back('{d: fr[i], sof: (i == 0), eof: (rst_at < 0 && i == fwd - 1), at: cyc + 2});
            if (accepted && rst_at < 0 && i == fwd - 1)
                dq.push_back('{len: fwd, ok: (fwd < MAX_LEN) && fcs_ok, chk_ok: (n >= 4),
                               err: (fwd < MIN_LEN) || (fwd >= MAX_LEN), at: cyc + 3});
            if (rst_at >= 0 && i == rst_at + 1) begin
                rst_n = 1'b1;
                @(negedge clk);
                check_all_zero("after_rst");
            end
        end
        for (int g = 0; g < gap; g++) drive(1'b0, 8'h00);
    endtask

    // Scoreboard: every output byte and status strobe must match the model in
    // value and cycle.
    always @(negedge clk) begin
        exp_byte_t e;
        exp_done_t s;
        if (rx_valid) begin
            if (eq.size() == 0) begin
                chk("spurious_valid", 1, 0);
            end else begin
                e = eq.pop_front();
                chk("data", rx_data, e.d);
                chk("sof", rx_sof, e.sof);
                chk("eof", rx_eof, e.eof);
                chk("byte_cycle", cyc, e.at);
            end
        end else if (rx_sof || rx_eof) begin
            chk("flag_without_valid", {rx_sof, rx_eof}, 0);
        end
        if (rx_done) begin
            if (dq.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                s = dq.pop_front();
                chk("done_len", rx_len, s.len);
                chk("done_len_err", rx_len_err, s.err);
                if (s.chk_ok) chk("done_crc_ok", rx_crc_ok, s.ok);
                chk("done_cycle", cyc, s.at);
            end
        end
    end

    initial begin
        int len;
        // Reset state
        rst_n = 1'b0;
        repeat (3) drive(1'b0, 8'h00);
        @(negedge clk);
        check_all_zero("reset");
        drive(1'b0, 8'h00);
        rst_n = 1'b1;
        repeat (2) drive(1'b0, 8'h00);

        // Minimum good frame, full preamble
        make_frame(64, -1);
        send(7, 8'hD5, 3, -1);
        // Same with data byte 10 corrupted
        make_frame(64, 9);
        send(7, 8'hD5, 3, -1);
        // Shortest preamble
        make_frame(100, -1);
        send(1, 8'hD5, 2, -1);
        // Broken preamble, then an over-long preamble: both dropped
        make_frame(64, -1);
        send(1, 8'h12, 2, -1);
        make_frame(64, -1);
        send(8, 8'hD5, 2, -1);
        // Runt frame with a good FCS
        make_frame(40, -1);
        send(7, 8'hD5, 2, -1);
        // One-byte frame: sof and eof together
        fr.delete();
        fr.push_back(8'($urandom));
        send(3, 8'hD5, 2, -1);
        // Over-long burst is truncated at MAX_LEN
        fr.delete();
        for (int i = 0; i < 1600; i++) fr.push_back(8'($urandom));
        send(7, 8'hD5, 2, -1);
        // Back-to-back frames with one idle cycle
        make_frame(64, -1);
        send(7, 8'hD5, 1, -1);
        make_frame(64, -1);
        send(7, 8'hD5, 1, -1);
        make_frame(70, -1);
        send(2, 8'hD5, 3, -1);
        // Reset during data byte 20; the rest of the burst must be ignored
        make_frame(64, -1);
        if (fr[20] == 8'h55) fr[20] = 8'hA0;
        send(7, 8'hD5, 2, 19);
        make_frame(64, -1);
        send(7, 8'hD5, 2, -1);
        // Random frames
        for (int f = 0; f < 20; f++) begin
            len = $urandom_range(4, 200);
            make_frame(len, ($urandom_range(0, 2) == 0) ? $urandom_range(0, len - 1) : -1);
            send($urandom_range(1, 7), 8'hD5, $urandom_range(1, 3), -1);
        end

        repeat (6) drive(1'b0, 8'h00);
        chk("exp_bytes_left", eq.size(), 0);
        chk("exp_done_left", dq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
